tcam_entry_loader: RTL
======================

TCAM_ENTRY_LOADER -- requirements
Module: tcam_entry_loader

Interface
REQ-001 SHALL have parameter ID_Width, default 4, destination/packet ID width.
REQ-002 SHALL have parameter AddressSize, default 4, CAM address width.
REQ-003 SHALL have parameter Bits, default 8, CAM entry and mask width.
REQ-004 SHALL have parameter Words, default 16, number of CAM entries (<= 2^AddressSize).
REQ-005 SHALL have parameter FlushCycles, default 2, FLUSH pulse length in cycles (>= 1).
REQ-006 SHALL have port clk, input, 1, sole clock; all logic on posedge.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port start, input, 1, request for a full table reprogram.
REQ-009 SHALL have port ent_valid, input, 1, entry-stream valid.
REQ-010 SHALL have port ent_ready, output, 1, entry-stream ready.
REQ-011 SHALL have port ent_data, input, Bits, entry data.
REQ-012 SHALL have port ent_mask, input, Bits, entry mask.
REQ-013 SHALL have port ent_last, input, 1, marks the final entry.
REQ-014 SHALL have port CS, output, 1, CAM chip select.
REQ-015 SHALL have port FLUSH, output, 1, CAM flush.
REQ-016 SHALL have port WR, output, 1, CAM write strobe.
REQ-017 SHALL have port VBE, output, 1, CAM valid-bit enable.
REQ-018 SHALL have port VBI, output, 1, CAM valid-bit input.
REQ-019 SHALL have port DCS, output, 1, CAM data chip select.
REQ-020 SHALL have port Data_Out, output, Bits, CAM write data.
REQ-021 SHALL have port Mask_Out, output, Bits, CAM write mask.
REQ-022 SHALL have port Addr_Out, output, AddressSize, CAM write address.
REQ-023 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-024 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-025 SHALL have port loaded_count, output, AddressSize+1, number of entries written.
REQ-026 SHALL have port trunc, output, 1, sticky flag: table filled before ent_last.

Function
REQ-027 SHALL implement FSM states IDLE, FLUSH, LOAD, WRITE and DONE, all outputs registered.
REQ-028 IDLE: start=1 -> FLUSH next cycle, clearing loaded_count and trunc; start ignored in all other states.
REQ-029 FLUSH: CS=1 and FLUSH=1 for exactly FlushCycles cycles, WR=0, then -> LOAD.
REQ-030 LOAD: ent_ready=1, CS=0 and WR=0; on ent_valid&ent_ready, capture ent_data, ent_mask and ent_last, and -> WRITE.
REQ-031 WRITE: one cycle with CS=WR=VBE=VBI=DCS=1, Data_Out/Mask_Out = captured values, Addr_Out = loaded_count[AddressSize-1:0].
REQ-032 WRITE exit: loaded_count increments by 1; if captured ent_last=1 or the new count equals Words -> DONE, else -> LOAD.
REQ-033 If the count reaches Words with captured ent_last=0, trunc SHALL be set and stay set until the next start or rst.
REQ-034 DONE: done=1 for one cycle, then -> IDLE; loaded_count and trunc SHALL hold until the next start.
REQ-035 ent_ready SHALL be 0 outside LOAD; back-to-back entries therefore sustain one write per 2 cycles.
REQ-036 Outside FLUSH and WRITE, CS, FLUSH, WR, VBE, VBI and DCS SHALL be 0; Data_Out, Mask_Out and Addr_Out SHALL hold their last values.
REQ-037 ent_valid with ent_last=1 on the very first entry SHALL produce exactly one write at Addr_Out=0.

Reset
REQ-038 rst=1 at a clock edge SHALL force IDLE and drive all outputs to 0 (loaded_count=0, trunc=0) on the next cycle, including mid-FLUSH or mid-WRITE.
REQ-039 After rst deasserts, the block SHALL stay in IDLE until start=1.

Verification
REQ-040 Basic load: start, then 3 entries (0xA5/0xFF, 0x3C/0xF0, 0x81/0x0F; last on the third) -> FLUSH high for 2 cycles; writes at Addr 0,1,2 with matching data/mask; done pulse; loaded_count=3; trunc=0.
REQ-041 Overflow: start, then 20 entries with no ent_last -> 16 writes at Addr 0..15; trunc=1; loaded_count=16; ent_ready=0 after the 16th entry is accepted.
REQ-042 Stall: ent_valid low for 5 cycles inside LOAD -> no WR, ent_ready stays 1, CS=0; write resumes on the next valid.
REQ-043 Reset mid-op: rst=1 during the second WRITE -> all outputs 0 next cycle; busy=0; no further WR.
REQ-044 Ignored start: start pulsed during LOAD -> no re-flush; loaded_count unaffected.
REQ-045 Single entry: start with one entry and ent_last=1 -> one write at Addr 0, done, loaded_count=1.

Source files
------------

// File: rtl/tcam_entry_loader.sv
// tcam_entry_loader
//   Reprograms a CAM table from a valid/ready entry stream. A start request
//   flushes the CAM. The block then takes one entry per handshake and writes
//   it to consecutive addresses from 0. It stops on ent_last or when the table
//   is full, and it reports how many entries it wrote and whether the stream
//   was truncated. Every output comes from a register.
//
//   Ports
//     clk, rst            sole clock, synchronous active-high reset
//     start               request a full table reprogram (honoured in IDLE only)
//     ent_valid/ready     entry stream handshake
//     ent_data/mask/last  entry payload and end-of-table marker
//     CS, FLUSH, WR       CAM chip select, flush, write strobe
//     VBE, VBI, DCS       CAM valid-bit enable/input, data chip select
//     Data_Out, Mask_Out  CAM write data/mask (held between writes)
//     Addr_Out            CAM write address (held between writes)
//     busy, done          activity flag, one-cycle completion pulse
//     loaded_count, trunc entries written, table-filled-before-last flag
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; results of the last load stay visible
//   FLUSH | CS+FLUSH asserted for FlushCycles cycles
//   LOAD  | ent_ready high, waiting for the next entry
//   WRITE | one-cycle CAM write of the captured entry
//   DONE  | one-cycle done pulse, then back to IDLE

module tcam_entry_loader #(
    parameter int ID_Width    = 4,
    parameter int AddressSize = 4,
    parameter int Bits        = 8,
    parameter int Words       = 16,
    parameter int FlushCycles = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   ent_valid,
    output logic                   ent_ready,
    input  logic [Bits-1:0]        ent_data,
    input  logic [Bits-1:0]        ent_mask,
    input  logic                   ent_last,
    output logic                   CS,
    output logic                   FLUSH,
    output logic                   WR,
    output logic                   VBE,
    output logic                   VBI,
    output logic                   DCS,
    output logic [Bits-1:0]        Data_Out,
    output logic [Bits-1:0]        Mask_Out,
    output logic [AddressSize-1:0] Addr_Out,
    output logic                   busy,
    output logic                   done,
    output logic [AddressSize:0]   loaded_count,
    output logic                   trunc
);

    // ID_Width belongs to the packet path this block sits beside. No ID logic
    // lives here, so the parameter only takes part in the elaboration sanity
    // check below.
    if (ID_Width < 1 || FlushCycles < 1 || Words < 1 || Words > (1 << AddressSize)) begin : g_param_check
        $error("tcam_entry_loader: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FLUSH = 3'd1,
        S_LOAD  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int FCW = (FlushCycles > 1) ? $clog2(FlushCycles) : 1;
    localparam logic [FCW-1:0]       FLUSH_LOAD = FCW'(FlushCycles - 1);
    localparam logic [AddressSize:0] WORDS_CNT  = (AddressSize + 1)'(Words);

    state_t                 state_q, state_d;
    logic [FCW-1:0]         flush_cnt_q;
    logic                   last_q;
    logic                   accept;
    logic [AddressSize:0]   count_inc;

    logic                   ent_ready_d, cs_d, flush_d, wr_d, vbe_d, vbi_d, dcs_d;
    logic [Bits-1:0]        data_d, mask_d;
    logic [AddressSize-1:0] addr_d;
    logic                   busy_d, done_d, trunc_d;
    logic [AddressSize:0]   count_d;

    // ent_ready is registered and is high exactly while in LOAD.
    assign accept    = ent_valid && ent_ready;
    assign count_inc = loaded_count + 1'b1;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_FLUSH;
            S_FLUSH: if (flush_cnt_q == '0) state_d = S_LOAD;
            S_LOAD:  if (accept) state_d = S_WRITE;
            S_WRITE: begin
                if (last_q || count_inc == WORDS_CNT) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic. It is computed from the next state so that the registered
    // outputs line up with the state they belong to. Write data comes straight
    // from the stream, because WRITE can only be entered on an accepted entry.
    always_comb begin
        ent_ready_d = 1'b0;
        cs_d        = 1'b0;
        flush_d     = 1'b0;
        wr_d        = 1'b0;
        vbe_d       = 1'b0;
        vbi_d       = 1'b0;
        dcs_d       = 1'b0;
        done_d      = 1'b0;
        data_d      = Data_Out;
        mask_d      = Mask_Out;
        addr_d      = Addr_Out;
        busy_d      = (state_d != S_IDLE);
        count_d     = loaded_count;
        trunc_d     = trunc;

        case (state_d)
            S_FLUSH: begin
                cs_d    = 1'b1;
                flush_d = 1'b1;
            end
            S_LOAD: begin
                ent_ready_d = 1'b1;
            end
            S_WRITE: begin
                cs_d   = 1'b1;
                wr_d   = 1'b1;
                vbe_d  = 1'b1;
                vbi_d  = 1'b1;
                dcs_d  = 1'b1;
                data_d = ent_data;
                mask_d = ent_mask;
                addr_d = loaded_count[AddressSize-1:0];
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: ;
        endcase

        // Result counters: cleared when a new load is accepted and advanced as
        // each write retires. In every other case they keep the last load's values.
        if (state_q == S_IDLE && start) begin
            count_d = '0;
            trunc_d = 1'b0;
        end else if (state_q == S_WRITE) begin
            count_d = count_inc;
            if (count_inc == WORDS_CNT && !last_q) begin
                trunc_d = 1'b1;
            end
        end
    end

    // Flush length down-counter. It is preloaded whenever the FSM is outside
    // FLUSH, and the FSM leaves FLUSH when the count reaches zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt_q <= FLUSH_LOAD;
        end else if (state_q != S_FLUSH) begin
            flush_cnt_q <= FLUSH_LOAD;
        end else if (flush_cnt_q != '0) begin
            flush_cnt_q <= flush_cnt_q - 1'b1;
        end
    end

    // Captured end-of-table marker of the entry being written.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b0;
        end else if (accept) begin
            last_q <= ent_last;
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ent_ready    <= 1'b0;
            CS           <= 1'b0;
            FLUSH        <= 1'b0;
            WR           <= 1'b0;
            VBE          <= 1'b0;
            VBI          <= 1'b0;
            DCS          <= 1'b0;
            Data_Out     <= '0;
            Mask_Out     <= '0;
            Addr_Out     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            loaded_count <= '0;
            trunc        <= 1'b0;
        end else begin
            ent_ready    <= ent_ready_d;
            CS           <= cs_d;
            FLUSH        <= flush_d;
            WR           <= wr_d;
            VBE          <= vbe_d;
            VBI          <= vbi_d;
            DCS          <= dcs_d;
            Data_Out     <= data_d;
            Mask_Out     <= mask_d;
            Addr_Out     <= addr_d;
            busy         <= busy_d;
            done         <= done_d;
            loaded_count <= count_d;
            trunc        <= trunc_d;
        end
    end

endmodule
